// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, request bundle, alignment mask.
package lsu_pkg;

   localparam int LSU_ADDR_W = 32;
   localparam int LSU_DATA_W = 32;
   localparam int LSU_TAG_W  = 5;

   localparam logic [1:0] MISALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } lsu_state_t;

   typedef struct packed {
      logic                  is_store;
      logic [LSU_ADDR_W-1:0] base;
      logic [11:0]           imm;
      logic [LSU_DATA_W-1:0] data;
      logic [LSU_TAG_W-1:0]  tag;
   } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Issue-side request, data-memory ports and result bus of the LSU.
// slave = LSU side; master = the surrounding issue stage / memory / result bus.
interface lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [ADDR_W-1:0] req_base;
   logic [11:0]       req_imm;
   logic [DATA_W-1:0] req_data;
   logic [TAG_W-1:0]  req_tag;

   logic              mem_rd_valid;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_wr_valid;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;

   logic              res_valid;
   logic              res_ready;
   logic [TAG_W-1:0]  res_tag;
   logic [DATA_W-1:0] res_data;
   logic              res_is_store;
   logic              res_err;

   modport slave (
      input  req_valid, req_is_store, req_base, req_imm, req_data, req_tag,
      input  mem_rd_data, res_ready,
      output req_ready, mem_rd_valid, mem_rd_addr,
      output mem_wr_valid, mem_wr_addr, mem_wr_data,
      output res_valid, res_tag, res_data, res_is_store, res_err
   );

   modport master (
      output req_valid, req_is_store, req_base, req_imm, req_data, req_tag,
      output mem_rd_data, res_ready,
      input  req_ready, mem_rd_valid, mem_rd_addr,
      input  mem_wr_valid, mem_wr_addr, mem_wr_data,
      input  res_valid, res_tag, res_data, res_is_store, res_err
   );
endinterface

// File: rtl/lsu_agu.sv
// Address generation: base + sign-extended 12-bit offset, word address and misalign flag.
// Purely combinational; no backpressure.
module lsu_agu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [11:0]       imm,
   output logic [ADDR_W-1:0] word_addr,
   output logic              misaligned
);

   logic [ADDR_W-1:0] ea;

   always_comb begin
      ea         = base + {{(ADDR_W-12){imm[11]}}, imm};
      word_addr  = {2'b00, ea[ADDR_W-1:2]};
      misaligned = |(ea[1:0] & MISALIGN_MASK);
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one op in flight; loads respond RD_LAT cycles after accept, stores/errors after 1.
// Result is held until res_ready; new requests are refused until the cycle after the handshake.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5,
   parameter int RD_LAT = 2
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   lsu_if.slave  bus
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              res_valid_q, res_valid_d;
   logic [TAG_W-1:0]  res_tag_q, res_tag_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_is_store_q, res_is_store_d;
   logic              res_err_q, res_err_d;

   logic [ADDR_W-1:0] word_addr;
   logic              misaligned;
   logic              accept;
   logic              rd_go;
   logic              wr_go;

   lsu_agu #(.ADDR_W(ADDR_W)) u_agu (
      .base       (bus.req_base),
      .imm        (bus.req_imm),
      .word_addr  (word_addr),
      .misaligned (misaligned)
   );

   assign bus.req_ready = (state_q == IDLE) && !flush && !rst;
   assign accept        = bus.req_valid && bus.req_ready;
   assign rd_go         = accept && !bus.req_is_store && !misaligned;
   assign wr_go         = accept && bus.req_is_store && !misaligned;

   assign bus.mem_rd_valid = rd_go;
   assign bus.mem_rd_addr  = rd_go ? word_addr : '0;
   assign bus.mem_wr_valid = wr_go;
   assign bus.mem_wr_addr  = wr_go ? word_addr : '0;
   assign bus.mem_wr_data  = wr_go ? bus.req_data : '0;

   assign bus.res_valid    = res_valid_q;
   assign bus.res_tag      = res_tag_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_is_store = res_is_store_q;
   assign bus.res_err      = res_err_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tag_d          = tag_q;
      res_tag_d      = res_tag_q;
      res_data_d     = res_data_q;
      res_is_store_d = res_is_store_q;
      res_err_d      = res_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.req_is_store || misaligned) begin
                  state_d        = RESP;
                  res_tag_d      = bus.req_tag;
                  res_data_d     = '0;
                  res_is_store_d = bus.req_is_store;
                  res_err_d      = misaligned;
               end else if (RD_LAT == 1) begin
                  // single-cycle memory: data is already due on the accept edge
                  state_d        = RESP;
                  res_tag_d      = bus.req_tag;
                  res_data_d     = bus.mem_rd_data;
                  res_is_store_d = 1'b0;
                  res_err_d      = 1'b0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(RD_LAT);
                  tag_d   = bus.req_tag;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(2)) begin
               state_d        = RESP;
               res_tag_d      = tag_q;
               res_data_d     = bus.mem_rd_data;
               res_is_store_d = 1'b0;
               res_err_d      = 1'b0;
            end
         end
         RESP: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // flush drops the op without touching the visible result registers
      if (flush && (state_q != IDLE)) begin
         state_d        = IDLE;
         cnt_d          = '0;
         res_tag_d      = res_tag_q;
         res_data_d     = res_data_q;
         res_is_store_d = res_is_store_q;
         res_err_d      = res_err_q;
      end

      res_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         tag_q          <= '0;
         res_valid_q    <= 1'b0;
         res_tag_q      <= '0;
         res_data_q     <= '0;
         res_is_store_q <= 1'b0;
         res_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tag_q          <= tag_d;
         res_valid_q    <= res_valid_d;
         res_tag_q      <= res_tag_d;
         res_data_q     <= res_data_d;
         res_is_store_q <= res_is_store_d;
         res_err_q      <= res_err_d;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a small word memory with a two-cycle read path.
module tb_lsu;
   import lsu_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;
   localparam int RD_LAT = 2;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_checks = 0;
   int   n_errors = 0;

   lsu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // read data is only valid in the one cycle the LSU samples it
   logic [DATA_W-1:0] mem [0:255];
   logic              rd_pend = 1'b0;
   logic [7:0]        rd_idx  = '0;

   always @(posedge clk) begin
      rd_pend <= bus.mem_rd_valid;
      rd_idx  <= bus.mem_rd_addr[7:0];
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
      end else if (bus.mem_wr_valid) begin
         mem[bus.mem_wr_addr[7:0]] <= bus.mem_wr_data;
      end
   end

   assign bus.mem_rd_data = rd_pend ? mem[rd_idx] : 32'hBAD0_BAD0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_req(input lsu_req_t r);
      bus.req_valid    = 1'b1;
      bus.req_is_store = r.is_store;
      bus.req_base     = r.base;
      bus.req_imm      = r.imm;
      bus.req_data     = r.data;
      bus.req_tag      = r.tag;
   endtask

   task automatic handshake(input string tag);
      cyc();
      bus.res_ready = 1'b1;
      smp();
      chk({tag, "_hs_vld"}, 64'(bus.res_valid), 64'd1);
      cyc();
      bus.res_ready = 1'b0;
      smp();
      chk({tag, "_post_vld"}, 64'(bus.res_valid), 64'd0);
      chk({tag, "_post_rdy"}, 64'(bus.req_ready), 64'd1);
   endtask

   initial begin
      rst              = 1'b1;
      flush            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_base     = '0;
      bus.req_imm      = '0;
      bus.req_data     = '0;
      bus.req_tag      = '0;
      bus.res_ready    = 1'b0;

      cyc();
      cyc();
      smp();
      chk("rst_rdy",    64'(bus.req_ready),    64'd0);
      chk("rst_vld",    64'(bus.res_valid),    64'd0);
      chk("rst_rd",     64'(bus.mem_rd_valid), 64'd0);
      chk("rst_wr",     64'(bus.mem_wr_valid), 64'd0);
      chk("rst_data",   64'(bus.res_data),     64'd0);
      cyc();
      rst = 1'b0;
      smp();
      chk("post_rst_rdy", 64'(bus.req_ready), 64'd1);

      // store: word address 0x41
      cyc();
      drive_req('{is_store: 1'b1, base: 32'h100, imm: 12'd4, data: 32'hDEAD_BEEF, tag: 5'd3});
      smp();
      chk("st_wr_vld",  64'(bus.mem_wr_valid), 64'd1);
      chk("st_wr_addr", 64'(bus.mem_wr_addr),  64'h41);
      chk("st_wr_data", 64'(bus.mem_wr_data),  64'hDEAD_BEEF);
      chk("st_rd_vld",  64'(bus.mem_rd_valid), 64'd0);
      chk("st_vld_T",   64'(bus.res_valid),    64'd0);
      cyc();
      bus.req_valid = 1'b0;
      smp();
      chk("st_vld",   64'(bus.res_valid),    64'd1);
      chk("st_tag",   64'(bus.res_tag),      64'd3);
      chk("st_isst",  64'(bus.res_is_store), 64'd1);
      chk("st_err",   64'(bus.res_err),      64'd0);
      chk("st_data",  64'(bus.res_data),     64'd0);
      chk("st_rdy",   64'(bus.req_ready),    64'd0);
      chk("st_wr_T1", 64'(bus.mem_wr_valid), 64'd0);
      handshake("st");

      // load back the stored word
      cyc();
      drive_req('{is_store: 1'b0, base: 32'h100, imm: 12'd4, data: 32'h0, tag: 5'd7});
      smp();
      chk("ld_rd_vld",  64'(bus.mem_rd_valid), 64'd1);
      chk("ld_rd_addr", 64'(bus.mem_rd_addr),  64'h41);
      chk("ld_wr_vld",  64'(bus.mem_wr_valid), 64'd0);
      cyc();
      bus.req_valid = 1'b0;
      smp();
      chk("ld_rdy_T1", 64'(bus.req_ready), 64'd0);
      chk("ld_vld_T1", 64'(bus.res_valid), 64'd0);
      chk("ld_rd_T1",  64'(bus.mem_rd_valid), 64'd0);
      cyc();
      smp();
      chk("ld_vld",  64'(bus.res_valid),    64'd1);
      chk("ld_data", 64'(bus.res_data),     64'hDEAD_BEEF);
      chk("ld_tag",  64'(bus.res_tag),      64'd7);
      chk("ld_isst", 64'(bus.res_is_store), 64'd0);
      chk("ld_err",  64'(bus.res_err),      64'd0);
      chk("ld_rdy",  64'(bus.req_ready),    64'd0);
      handshake("ld");

      // misaligned load
      cyc();
      drive_req('{is_store: 1'b0, base: 32'h103, imm: 12'd0, data: 32'h0, tag: 5'd9});
      smp();
      chk("mis_rd_vld", 64'(bus.mem_rd_valid), 64'd0);
      chk("mis_rdy",    64'(bus.req_ready),    64'd1);
      cyc();
      bus.req_valid = 1'b0;
      smp();
      chk("mis_vld",  64'(bus.res_valid),    64'd1);
      chk("mis_err",  64'(bus.res_err),      64'd1);
      chk("mis_data", 64'(bus.res_data),     64'd0);
      chk("mis_tag",  64'(bus.res_tag),      64'd9);
      chk("mis_isst", 64'(bus.res_is_store), 64'd0);
      handshake("mis");

      // misaligned store: no write, error completion flagged as store
      cyc();
      drive_req('{is_store: 1'b1, base: 32'h10, imm: 12'd1, data: 32'h55, tag: 5'd10});
      smp();
      chk("mst_wr_vld", 64'(bus.mem_wr_valid), 64'd0);
      cyc();
      bus.req_valid = 1'b0;
      smp();
      chk("mst_err",  64'(bus.res_err),      64'd1);
      chk("mst_isst", 64'(bus.res_is_store), 64'd1);
      chk("mst_tag",  64'(bus.res_tag),      64'd10);
      handshake("mst");

      // negative offset to word 0, then hold the result under backpressure
      cyc();
      drive_req('{is_store: 1'b0, base: 32'h10, imm: 12'hFF0, data: 32'h0, tag: 5'd2});
      smp();
      chk("neg_rd_addr", 64'(bus.mem_rd_addr), 64'h0);
      cyc();
      bus.req_valid = 1'b0;
      smp();
      cyc();
      smp();
      chk("neg_vld",  64'(bus.res_valid), 64'd1);
      chk("neg_data", 64'(bus.res_data),  64'hA500_0000);
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (i == 0) drive_req('{is_store: 1'b0, base: 32'h40, imm: 12'd0, data: 32'h0, tag: 5'd1});
         smp();
         chk("hold_vld",  64'(bus.res_valid),    64'd1);
         chk("hold_data", 64'(bus.res_data),     64'hA500_0000);
         chk("hold_tag",  64'(bus.res_tag),      64'd2);
         chk("hold_rdy",  64'(bus.req_ready),    64'd0);
         chk("hold_rd",   64'(bus.mem_rd_valid), 64'd0);
      end
      bus.req_valid = 1'b0;
      handshake("neg");

      // effective address wraps below zero
      cyc();
      drive_req('{is_store: 1'b0, base: 32'h8, imm: 12'hFF0, data: 32'h0, tag: 5'd11});
      smp();
      chk("wrap_rd_addr", 64'(bus.mem_rd_addr), 64'h3FFF_FFFE);
      cyc();
      bus.req_valid = 1'b0;
      cyc();
      smp();
      chk("wrap_data", 64'(bus.res_data), 64'hA500_00FE);
      chk("wrap_tag",  64'(bus.res_tag),  64'd11);
      handshake("wrap");

      // flush a waiting load, then a following load returns its own data
      cyc();
      drive_req('{is_store: 1'b0, base: 32'h20, imm: 12'd0, data: 32'h0, tag: 5'd4});
      smp();
      chk("fl_rd_vld", 64'(bus.mem_rd_valid), 64'd1);
      cyc();
      bus.req_valid = 1'b0;
      flush         = 1'b1;
      smp();
      chk("fl_rdy_T1", 64'(bus.req_ready), 64'd0);
      cyc();
      flush = 1'b0;
      drive_req('{is_store: 1'b0, base: 32'h24, imm: 12'd0, data: 32'h0, tag: 5'd5});
      smp();
      chk("fl_rdy_T2",   64'(bus.req_ready),    64'd1);
      chk("fl_vld_T2",   64'(bus.res_valid),    64'd0);
      chk("fl2_rd_vld",  64'(bus.mem_rd_valid), 64'd1);
      chk("fl2_rd_addr", 64'(bus.mem_rd_addr),  64'h9);
      cyc();
      bus.req_valid = 1'b0;
      smp();
      chk("fl_vld_T3", 64'(bus.res_valid), 64'd0);
      cyc();
      smp();
      chk("fl2_vld",  64'(bus.res_valid), 64'd1);
      chk("fl2_data", 64'(bus.res_data),  64'hA500_0009);
      chk("fl2_tag",  64'(bus.res_tag),   64'd5);
      handshake("fl2");

      // flush and handshake together in RESP
      cyc();
      drive_req('{is_store: 1'b1, base: 32'h30, imm: 12'd0, data: 32'h77, tag: 5'd6});
      cyc();
      bus.req_valid = 1'b0;
      smp();
      chk("flr_tag", 64'(bus.res_tag), 64'd6);
      cyc();
      flush         = 1'b1;
      bus.res_ready = 1'b1;
      smp();
      chk("flr_rdy_fl", 64'(bus.req_ready), 64'd0);
      cyc();
      flush         = 1'b0;
      bus.res_ready = 1'b0;
      smp();
      chk("flr_vld", 64'(bus.res_valid), 64'd0);
      chk("flr_rdy", 64'(bus.req_ready), 64'd1);

      // reset while a load waits
      cyc();
      drive_req('{is_store: 1'b0, base: 32'h40, imm: 12'd0, data: 32'h0, tag: 5'd12});
      cyc();
      bus.req_valid = 1'b0;
      rst           = 1'b1;
      smp();
      chk("mrst_rdy_in", 64'(bus.req_ready), 64'd0);
      cyc();
      rst = 1'b0;
      smp();
      chk("mrst_vld",  64'(bus.res_valid),    64'd0);
      chk("mrst_rdy",  64'(bus.req_ready),    64'd1);
      chk("mrst_rd",   64'(bus.mem_rd_valid), 64'd0);
      chk("mrst_tag",  64'(bus.res_tag),      64'd0);
      chk("mrst_isst", 64'(bus.res_is_store), 64'd0);
      chk("mrst_data", 64'(bus.res_data),     64'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         smp();
         chk("mrst_quiet", 64'(bus.res_valid), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
